// File: rtl/tree_arbiter_pkg.sv
// rtl/tree_arbiter_pkg.sv - shared types and helpers for the tree arbiter
package tree_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Requester ID width; a single requester still needs one bit of ID.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tree_arbiter_id_fifo.sv
// rtl/tree_arbiter_id_fifo.sv - FIFO of granted requester IDs awaiting results
module id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // A pop frees the slot on the same edge, so push is legal when full and popping.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/tree_arbiter.sv
// rtl/tree_arbiter.sv - round-robin packet arbiter in front of a shared adder tree
module tree_arbiter
    import tree_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int IN_LANES       = 4,
    parameter int OUT_LANES      = 1,
    parameter int NUM_REQUESTERS = 4,
    parameter int ID_FIFO_DEPTH  = 4
) (
    input  logic                                          clock_i,
    input  logic                                          reset_i,
    input  logic [NUM_REQUESTERS-1:0]                     req_tvalid_i,
    output logic [NUM_REQUESTERS-1:0]                     req_tready_o,
    input  logic [NUM_REQUESTERS*IN_LANES*DATA_WIDTH-1:0] req_tdata_i,
    input  logic [NUM_REQUESTERS-1:0]                     req_tlast_i,
    output logic                                          tree_tvalid_o,
    input  logic                                          tree_tready_i,
    output logic [IN_LANES*DATA_WIDTH-1:0]                tree_tdata_o,
    output logic                                          tree_tlast_o,
    input  logic                                          tree_tvalid_i,
    output logic                                          tree_tready_o,
    input  logic [OUT_LANES*DATA_WIDTH-1:0]               tree_tdata_i,
    input  logic                                          tree_tlast_i,
    output logic [NUM_REQUESTERS-1:0]                     resp_tvalid_o,
    input  logic [NUM_REQUESTERS-1:0]                     resp_tready_i,
    output logic [OUT_LANES*DATA_WIDTH-1:0]               resp_tdata_o,
    output logic                                          resp_tlast_o
);

    localparam int ID_W   = id_width(NUM_REQUESTERS);
    localparam int BEAT_W = IN_LANES * DATA_WIDTH;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] winner;
    logic            winner_found;
    logic            grant_now;
    logic            pkt_done;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ID_W-1:0] head;
    logic            pop;

    // Round-robin search starting one past the last completed grant.
    always_comb begin
        int idx;
        winner       = '0;
        winner_found = 1'b0;
        idx          = 0;
        for (int i = 1; i <= NUM_REQUESTERS; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQUESTERS;
            if (!winner_found && req_tvalid_i[idx]) begin
                winner       = idx[ID_W-1:0];
                winner_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_now     = 1'b0;
        pkt_done      = 1'b0;
        req_tready_o  = '0;
        tree_tvalid_o = 1'b0;
        tree_tlast_o  = 1'b0;
        tree_tdata_o  = req_tdata_i[int'(grant)*BEAT_W +: BEAT_W];
        case (state)
            IDLE: begin
                if (!reset_i && winner_found && (!fifo_full || pop)) begin
                    grant_now = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!reset_i) begin
                    tree_tvalid_o       = req_tvalid_i[grant];
                    tree_tlast_o        = req_tlast_i[grant];
                    req_tready_o[grant] = tree_tready_i;
                    if (tree_tvalid_o && tree_tready_i && tree_tlast_o) begin
                        pkt_done  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_W'(NUM_REQUESTERS - 1);
        end else begin
            state <= state_nxt;
            if (grant_now) begin
                grant <= winner;
            end
            if (pkt_done) begin
                last_grant <= grant;
            end
        end
    end

    // Results come back in grant order, so the FIFO head names their owner.
    always_comb begin
        resp_tvalid_o = '0;
        tree_tready_o = 1'b0;
        if (!fifo_empty && !reset_i) begin
            resp_tvalid_o[head] = tree_tvalid_i;
            tree_tready_o       = resp_tready_i[head];
        end
    end

    assign pop          = tree_tvalid_i && tree_tready_o && tree_tlast_i;
    assign resp_tdata_o = tree_tdata_i;
    assign resp_tlast_o = tree_tlast_i;

    id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (ID_FIFO_DEPTH)
    ) u_id_fifo (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .push      (grant_now),
        .push_data (winner),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

endmodule

// File: tb/tb_tree_arbiter.sv
// tb/tb_tree_arbiter.sv - directed self-checking bench for tree_arbiter
module tb_tree_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_tvalid;
    logic [3:0]   req_tready;
    logic [127:0] req_tdata;
    logic [3:0]   req_tlast;
    logic         tree_tvalid;
    logic         tree_tready;
    logic [31:0]  tree_tdata;
    logic         tree_tlast;
    logic         res_tvalid;
    logic         res_tready_o;
    logic [7:0]   res_tdata;
    logic         res_tlast;
    logic [3:0]   resp_tvalid;
    logic [3:0]   resp_tready;
    logic [7:0]   resp_tdata;
    logic         resp_tlast;

    int           pend [4];
    int           beat [4];
    logic         rearm;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    tree_arbiter #(
        .DATA_WIDTH     (8),
        .IN_LANES       (4),
        .OUT_LANES      (1),
        .NUM_REQUESTERS (4),
        .ID_FIFO_DEPTH  (2)
    ) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .req_tvalid_i  (req_tvalid),
        .req_tready_o  (req_tready),
        .req_tdata_i   (req_tdata),
        .req_tlast_i   (req_tlast),
        .tree_tvalid_o (tree_tvalid),
        .tree_tready_i (tree_tready),
        .tree_tdata_o  (tree_tdata),
        .tree_tlast_o  (tree_tlast),
        .tree_tvalid_i (res_tvalid),
        .tree_tready_o (res_tready_o),
        .tree_tdata_i  (res_tdata),
        .tree_tlast_i  (res_tlast),
        .resp_tvalid_o (resp_tvalid),
        .resp_tready_i (resp_tready),
        .resp_tdata_o  (resp_tdata),
        .resp_tlast_o  (resp_tlast)
    );

    // Requester r, beat b presents {r, b, C0DE}; tlast on its final beat.
    always_comb begin
        req_tvalid = '0;
        req_tlast  = '0;
        req_tdata  = '0;
        for (int r = 0; r < 4; r++) begin
            req_tvalid[r]         = (pend[r] != 0);
            req_tlast[r]          = (pend[r] == 1);
            req_tdata[r*32 +: 32] = {8'(r), 8'(beat[r]), 16'hC0DE};
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic advance();
        logic [3:0] hs;
        #1;
        hs = req_tvalid & req_tready;
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++) begin
            if (hs[r]) begin
                beat[r]++;
                if (!rearm) pend[r]--;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic start_reset();
        rst         = 1'b1;
        rearm       = 1'b0;
        tree_tready = 1'b1;
        res_tvalid  = 1'b0;
        res_tdata   = 8'h00;
        res_tlast   = 1'b0;
        resp_tready = 4'hF;
        for (int r = 0; r < 4; r++) begin
            pend[r] = 0;
            beat[r] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [31:0] e_data  [1:7];
    logic [3:0]  e_ready [1:8];
    logic        e_valid [1:8];
    logic        e_last  [1:7];
    int          grants  [5];
    int          ng;

    initial begin
        e_data  = '{32'h0000C0DE, 32'h0001C0DE, 32'h0002C0DE, 32'h0,
                    32'h0200C0DE, 32'h0201C0DE, 32'h0202C0DE};
        e_ready = '{4'b0001, 4'b0001, 4'b0001, 4'b0000,
                    4'b0100, 4'b0100, 4'b0100, 4'b0000};
        e_valid = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        e_last  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state, with every input trying to provoke activity.
        start_reset();
        for (int r = 0; r < 4; r++) pend[r] = 2;
        res_tvalid = 1'b1;
        res_tlast  = 1'b1;
        #1;
        chk("rst_req_tready", req_tready, 4'b0000);
        chk("rst_tree_tvalid", tree_tvalid, 1'b0);
        chk("rst_tree_tready", res_tready_o, 1'b0);
        chk("rst_resp_tvalid", resp_tvalid, 4'b0000);

        // Requesters 0 and 2 offer 3-beat packets together.
        start_reset();
        release_reset();
        pend[0] = 3;
        pend[2] = 3;
        @(negedge clk);
        #1;
        chk("pkt_post_rst_tvalid", tree_tvalid, 1'b0);
        chk("pkt_post_rst_tready", req_tready, 4'b0000);
        for (int n = 1; n <= 8; n++) begin
            advance();
            chk($sformatf("pkt_tvalid_%0d", n), tree_tvalid, e_valid[n]);
            chk($sformatf("pkt_ready_%0d", n), req_tready, e_ready[n]);
            if (n <= 7 && e_valid[n]) begin
                chk($sformatf("pkt_tdata_%0d", n), tree_tdata, e_data[n]);
                chk($sformatf("pkt_tlast_%0d", n), tree_tlast, e_last[n]);
            end
        end
        res_tvalid = 1'b1;
        res_tlast  = 1'b1;
        res_tdata  = 8'h11;
        #1;
        chk("res0_resp_tvalid", resp_tvalid, 4'b0001);
        chk("res0_tree_tready", res_tready_o, 1'b1);
        chk("res0_tdata", resp_tdata, 8'h11);
        chk("res0_tlast", resp_tlast, 1'b1);
        advance();
        res_tdata = 8'h22;
        #1;
        chk("res2_resp_tvalid", resp_tvalid, 4'b0100);
        chk("res2_tdata", resp_tdata, 8'h22);
        advance();
        chk("res_empty_tready", res_tready_o, 1'b0);
        chk("res_empty_resp_tvalid", resp_tvalid, 4'b0000);

        // All requesters continuously valid with 1-beat packets.
        start_reset();
        release_reset();
        rearm      = 1'b1;
        res_tvalid = 1'b1;
        res_tlast  = 1'b1;
        for (int r = 0; r < 4; r++) pend[r] = 1;
        @(negedge clk);
        #1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            if (req_tready != 4'b0000) begin
                for (int r = 0; r < 4; r++) begin
                    if (req_tready[r]) grants[ng] = r;
                end
                ng++;
            end
            advance();
        end
        chk("rr_grant_count", 64'(ng), 64'd5);
        for (int g = 0; g < ng; g++) begin
            chk($sformatf("rr_grant_%0d", g), 64'(grants[g]), 64'(g % 4));
        end

        // FIFO full: stays IDLE until a result pop, then grants on the same edge.
        start_reset();
        release_reset();
        pend[0] = 1;
        pend[1] = 1;
        pend[2] = 1;
        @(negedge clk);
        #1;
        advance();
        chk("full_g0", req_tready, 4'b0001);
        advance();
        advance();
        chk("full_g1", req_tready, 4'b0010);
        advance();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("full_idle_tvalid_%0d", c), tree_tvalid, 1'b0);
            chk($sformatf("full_idle_ready_%0d", c), req_tready, 4'b0000);
            advance();
        end
        res_tvalid = 1'b1;
        res_tlast  = 1'b1;
        #1;
        chk("full_head_resp", resp_tvalid, 4'b0001);
        chk("full_head_tready", res_tready_o, 1'b1);
        advance();
        chk("full_pop_grant_tvalid", tree_tvalid, 1'b1);
        chk("full_pop_grant_ready", req_tready, 4'b0100);
        chk("full_pop_next_head", resp_tvalid, 4'b0010);

        // Result backpressure from the owning requester.
        start_reset();
        release_reset();
        pend[1] = 1;
        @(negedge clk);
        #1;
        advance();
        chk("bp_grant", req_tready, 4'b0010);
        advance();
        res_tvalid  = 1'b1;
        res_tlast   = 1'b1;
        res_tdata   = 8'h5A;
        resp_tready = 4'b1101;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_tready_%0d", c), res_tready_o, 1'b0);
            chk($sformatf("bp_resp_tvalid_%0d", c), resp_tvalid, 4'b0010);
            chk($sformatf("bp_tdata_%0d", c), resp_tdata, 8'h5A);
            advance();
        end
        resp_tready = 4'hF;
        #1;
        chk("bp_release_tready", res_tready_o, 1'b1);
        advance();
        chk("bp_popped", resp_tvalid, 4'b0000);

        // Reset on the second beat of a 4-beat packet.
        start_reset();
        release_reset();
        pend[1] = 4;
        @(negedge clk);
        #1;
        advance();
        advance();
        chk("mid_beat1_tdata", tree_tdata, 32'h0101C0DE);
        res_tvalid = 1'b1;
        res_tlast  = 1'b1;
        rst        = 1'b1;
        pend[0]    = 1;
        #1;
        chk("mid_rst_tvalid", tree_tvalid, 1'b0);
        chk("mid_rst_ready", req_tready, 4'b0000);
        advance();
        rst = 1'b0;
        #1;
        chk("mid_after_tvalid", tree_tvalid, 1'b0);
        chk("mid_after_ready", req_tready, 4'b0000);
        chk("mid_after_fifo_tready", res_tready_o, 1'b0);
        chk("mid_after_resp_tvalid", resp_tvalid, 4'b0000);
        advance();
        chk("mid_regrant", req_tready, 4'b0001);
        chk("mid_regrant_tdata", tree_tdata, 32'h0000C0DE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
